spi_device_interface: RTL and testbench



---
 rtl/spi_device_interface.sv | 166 ++++++++++++++++
 tb/tb_spi_device_interface.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_device_interface.sv
// SPI mode-0 target byte engine: oversampled pins, MOSI deserializer and
// MISO serializer with a single-byte TX holding register.
module spi_device_interface #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       cs_start,
  output logic       cs_end,
  output logic       rx_data_valid,
  output logic [7:0] rx_data,
  output logic       tx_ready,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_data,
  output logic       tx_underflow
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_hist, r_cs_hist;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt;
  logic [7:0] r_rx_shift, r_rx_data, r_tx_shift, r_hold;
  logic       r_hold_full, r_rx_done, r_rx_valid, r_oe;
  logic       r_cs_start, r_cs_end, r_underflow;

  logic w_sck, w_cs_n, w_mosi;
  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic w_start, w_end, w_rise_act, w_fall_act, w_load;

  // Idle values (sck low, cs_n high) keep a held-low CS from looking
  // like an ongoing transfer after reset: it shows up as a fresh fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_hist  <= 1'b0;
      r_cs_hist   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_hist  <= r_sck_sync[SYNC_STAGES-1];
      r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck  & ~r_sck_hist;
  assign w_sck_fall = ~w_sck  &  r_sck_hist;
  assign w_cs_fall  = ~w_cs_n &  r_cs_hist;
  assign w_cs_rise  =  w_cs_n & ~r_cs_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // CS deassert takes priority over any SCK edge seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_rise_act  = 1'b0;
    w_fall_act  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_end       = 1'b1;
        end else begin
          w_rise_act = w_sck_rise;
          w_fall_act = w_sck_fall;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load = w_start | (w_fall_act & (r_cnt == 3'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_done   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_oe        <= 1'b0;
      r_cs_start  <= 1'b0;
      r_cs_end    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_cs_start  <= w_start;
      r_cs_end    <= w_end;
      r_rx_done   <= 1'b0;
      r_rx_valid  <= r_rx_done;
      r_underflow <= 1'b0;

      if (w_start || w_end) begin
        r_cnt      <= '0;
        r_rx_shift <= '0;
      end
      if (w_start) r_oe <= 1'b1;
      if (w_end) begin
        r_oe       <= 1'b0;
        r_tx_shift <= '0;
      end

      if (w_rise_act) begin
        r_rx_shift <= {r_rx_shift[6:0], w_mosi};
        r_cnt      <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_rx_data <= {r_rx_shift[6:0], w_mosi};
          r_rx_done <= 1'b1;
        end
      end

      if (w_load) begin
        r_tx_shift  <= r_hold_full ? r_hold : FILL_BYTE;
        r_underflow <= ~r_hold_full;
      end else if (w_fall_act) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      // A write landing with a load is kept for the next byte; the load
      // itself already took the old contents (or the fill byte).
      if (tx_data_valid && !r_hold_full) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign spi_miso      = r_tx_shift[7];
  assign spi_miso_oe   = r_oe;
  assign cs_start      = r_cs_start;
  assign cs_end        = r_cs_end;
  assign rx_data_valid = r_rx_valid;
  assign rx_data       = r_rx_data;
  assign tx_ready      = ~r_hold_full;
  assign tx_underflow  = r_underflow;

endmodule

// File: tb/tb_spi_device_interface.sv
// Directed bench for spi_device_interface: host-side SPI driver, expected
// RX byte queue drained by a per-cycle compare process, pulse counters.
module tb_spi_device_interface;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, cs_start, cs_end;
  logic       rx_data_valid, tx_ready, tx_underflow;
  logic [7:0] rx_data;
  logic       tx_data_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  int n_checks = 0, n_err = 0;
  int n_start = 0, n_end = 0, n_under = 0;
  int s0, e0, u0;
  logic [7:0] rx_q[$];

  spi_device_interface #(.SYNC_STAGES(2), .FILL_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .cs_start(cs_start), .cs_end(cs_end), .rx_data_valid(rx_data_valid),
    .rx_data(rx_data), .tx_ready(tx_ready), .tx_data_valid(tx_data_valid),
    .tx_data(tx_data), .tx_underflow(tx_underflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Every received byte must match the oldest complete byte the host sent.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cs_start)     n_start++;
      if (cs_end)       n_end++;
      if (tx_underflow) n_under++;
      if (rx_data_valid) begin
        if (rx_q.size() == 0) chk("rx_unexpected", {24'h0, rx_data}, 32'hffff_ffff);
        else                  chk("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data_valid = 1'b1;
    tx_data       = b;
    @(negedge clk);
    tx_data_valid = 1'b0;
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  // Mode 0: drive MOSI in the low phase, sample MISO just before the rise.
  // With end_cs the final SCK fall and CS rise happen together.
  task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi, input bit chk_mi,
                      input int nbits, input bit end_cs);
    logic [7:0] got;
    got = 8'h00;
    if (nbits == 8) rx_q.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      wait_clk(8);
      got[7-i] = spi_miso;
      if (i == 0) chk("oe_active", {31'h0, spi_miso_oe}, 32'h1);
      spi_sck = 1'b1;
      wait_clk(8);
      spi_sck = 1'b0;
      if (end_cs && i == nbits - 1) spi_cs_n = 1'b1;
    end
    wait_clk(4);
    if (chk_mi) chk("miso_byte", {24'h0, got}, {24'h0, exp_mi});
  endtask

  initial begin
    // reset values
    wait_clk(3);
    chk("rst_miso", {31'h0, spi_miso}, 32'h0);
    chk("rst_oe",   {31'h0, spi_miso_oe}, 32'h0);
    chk("rst_pulses", {28'h0, cs_start, cs_end, rx_data_valid, tx_underflow}, 32'h0);
    chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
    chk("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    rst_n = 1'b1;
    wait_clk(6);

    // single byte, preloaded TX
    write_tx(8'hA5);
    chk("t1_tx_ready_full", {31'h0, tx_ready}, 32'h0);
    s0 = n_start; e0 = n_end; u0 = n_under;
    cs_begin();
    xfer(8'h3C, 8'hA5, 1, 8, 1);
    wait_clk(16);
    chk("t1_rx_drained", rx_q.size(), 0);
    chk("t1_rx_data", {24'h0, rx_data}, 32'h3C);
    chk("t1_no_underflow", n_under - u0, 0);
    chk("t1_cs_start", n_start - s0, 1);
    chk("t1_cs_end", n_end - e0, 1);
    chk("t1_oe_idle", {31'h0, spi_miso_oe}, 32'h0);
    chk("t1_miso_idle", {31'h0, spi_miso}, 32'h0);
    chk("t1_tx_ready", {31'h0, tx_ready}, 32'h1);

    // three-byte burst with refills
    u0 = n_under;
    write_tx(8'h11);
    cs_begin();
    chk("t2_ready0", {31'h0, tx_ready}, 32'h1);
    write_tx(8'h22);
    xfer(8'h01, 8'h11, 1, 8, 0);
    chk("t2_ready1", {31'h0, tx_ready}, 32'h1);
    write_tx(8'h33);
    xfer(8'h02, 8'h22, 1, 8, 0);
    xfer(8'h03, 8'h33, 1, 8, 1);
    wait_clk(16);
    chk("t2_rx_drained", rx_q.size(), 0);
    chk("t2_rx_data", {24'h0, rx_data}, 32'h03);
    chk("t2_no_underflow", n_under - u0, 0);

    // empty holding register at CS fall
    u0 = n_under; s0 = n_start;
    cs_begin();
    chk("t3_oe", {31'h0, spi_miso_oe}, 32'h1);
    chk("t3_cs_start", n_start - s0, 1);
    chk("t3_underflow", n_under - u0, 1);
    xfer(8'h5A, 8'h00, 1, 8, 1);
    wait_clk(16);
    chk("t3_underflow_once", n_under - u0, 1);
    chk("t3_rx_data", {24'h0, rx_data}, 32'h5A);

    // CS raised after 5 SCK cycles
    e0 = n_end;
    cs_begin();
    xfer(8'hC7, 8'h00, 0, 5, 1);
    wait_clk(16);
    chk("t4_no_rx", rx_q.size(), 0);
    chk("t4_rx_data_kept", {24'h0, rx_data}, 32'h5A);
    chk("t4_cs_end", n_end - e0, 1);
    chk("t4_oe_idle", {31'h0, spi_miso_oe}, 32'h0);
    cs_begin();
    xfer(8'hF0, 8'h00, 1, 8, 1);
    wait_clk(16);
    chk("t4_rx_data", {24'h0, rx_data}, 32'hF0);

    // write while full is dropped
    write_tx(8'h55);
    write_tx(8'h99);
    chk("t5_tx_ready", {31'h0, tx_ready}, 32'h0);
    u0 = n_under;
    cs_begin();
    xfer(8'h81, 8'h55, 1, 8, 1);
    wait_clk(16);
    chk("t5_no_underflow", n_under - u0, 0);
    cs_begin();
    xfer(8'h42, 8'h00, 1, 8, 1);
    wait_clk(16);
    chk("t5_underflow", n_under - u0, 1);
    chk("t5_rx_data", {24'h0, rx_data}, 32'h42);

    // reset in the middle of the second byte
    write_tx(8'hAA);
    cs_begin();
    xfer(8'h12, 8'hAA, 1, 8, 0);
    xfer(8'hE5, 8'h00, 0, 3, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_miso_oe", {30'h0, spi_miso, spi_miso_oe}, 32'h0);
    chk("t6_rst_pulses", {28'h0, cs_start, cs_end, rx_data_valid, tx_underflow}, 32'h0);
    chk("t6_rst_rx_data", {24'h0, rx_data}, 32'h0);
    chk("t6_rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    rst_n = 1'b1;
    xfer(8'h5B, 8'h00, 0, 5, 1);
    wait_clk(16);
    chk("t6_no_rx", rx_q.size(), 0);
    write_tx(8'hC3);
    cs_begin();
    xfer(8'h7E, 8'hC3, 1, 8, 1);
    wait_clk(16);
    chk("t6_rx_data", {24'h0, rx_data}, 32'h7E);
    chk("final_rx_drained", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
